// File: rtl/nor_4b_bist_pkg.sv
// Shared types and constants for the nor_4b stimulus-and-check engine.
package nor_4b_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int VEC_W   = 8;
  localparam int OP_W    = 4;
  localparam int LAT_MAX = 3;

  // One in-flight check: the vector that was applied and the NOR it should produce.
  typedef struct packed {
    logic            vld;
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
    logic [OP_W-1:0] o;
  } exp_t;

endpackage

// File: rtl/nor_4b_exp_pipe.sv
// Delay line that lines up each applied vector with the DUT result it produces.
// Zero depth collapses to a wire for a purely combinational DUT.
module nor_4b_exp_pipe
  import nor_4b_bist_pkg::*;
#(
  parameter int DUT_LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  exp_t din,
  output exp_t dout
);

  generate
    if (DUT_LAT == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, rst_n};
      assign dout = din;
    end else begin : g_dly
      logic                vld_p [DUT_LAT];
      logic [3*OP_W-1:0]   dat_p [DUT_LAT];

      // Valid flags are cleared on reset so no stale vector is ever checked.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DUT_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
          vld_p[0] <= din.vld;
          for (int i = 1; i < DUT_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      // Payload shifts unconditionally; it is only meaningful alongside its valid.
      always_ff @(posedge clk) begin
        dat_p[0] <= {din.x, din.y, din.o};
        for (int i = 1; i < DUT_LAT; i++) dat_p[i] <= dat_p[i-1];
      end

      assign dout = {vld_p[DUT_LAT-1], dat_p[DUT_LAT-1]};
    end
  endgenerate

endmodule

// File: rtl/nor_4b_bist.sv
// Sweeps all 256 (x,y) operand pairs through a 4-bit NOR cell, compares each
// result against ~(x|y) and reports mismatch count, first failing vector and pass.
module nor_4b_bist
  import nor_4b_bist_pkg::*;
#(
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       dut_x,
  output logic [3:0]       dut_y,
  input  logic [3:0]       dut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       first_fail_x,
  output logic [3:0]       first_fail_y
);

  localparam int DRN_W = $clog2(LAT_MAX + 1);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [DRN_W-1:0] drain_cnt;
  exp_t             push;
  exp_t             chk;
  logic             miss;
  logic [CNT_W-1:0] err_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign dut_x = vec[VEC_W-1:OP_W];
  assign dut_y = vec[OP_W-1:0];

  assign push.vld = (state == RUN);
  assign push.x   = dut_x;
  assign push.y   = dut_y;
  assign push.o   = ~(dut_x | dut_y);

  nor_4b_exp_pipe #(.DUT_LAT(DUT_LAT)) u_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (push),
    .dout (chk)
  );

  // Case inequality makes an X/Z on dut_o a miss in simulation; hardware sees plain !=.
  always_comb begin
    miss    = chk.vld && (dut_o !== chk.o);
    err_nxt = miss ? sat_inc(err_count) : err_count;
  end

  // Sequencer: vector counter, drain timer, result capture and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      vec          <= '0;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_fail_x <= '0;
      first_fail_y <= '0;
    end else begin
      err_count <= err_nxt;
      if (miss && (err_count == '0)) begin
        first_fail_x <= chk.x;
        first_fail_y <= chk.y;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            vec          <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            first_fail_x <= '0;
            first_fail_y <= '0;
          end
        end
        RUN: begin
          if (vec == '1) begin
            if (DUT_LAT > 0) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end
          end else begin
            vec <= vec + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRN_W'(DUT_LAT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_4b_bist.sv
// Directed bench for nor_4b_bist: a zero-latency instance fed by selectable
// good/faulty NOR models, and a two-cycle-latency instance fed by a registered NOR.
module tb_nor_4b_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start2;
  logic [2:0] mode;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [3:0] dut_x0, dut_y0, dut_o0, dut_x2, dut_y2, dut_o2;
  logic       busy0, done0, pass0, busy2, done2, pass2;
  logic [8:0] err0, err2;
  logic [3:0] ffx0, ffy0, ffx2, ffy2;
  logic [3:0] m3a, m3b, d2a, d2b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two output flops after a NOR, for each instance.
  always @(posedge clk) begin
    m3a <= ~(dut_x0 | dut_y0);
    m3b <= m3a;
    d2a <= ~(dut_x2 | dut_y2);
    d2b <= d2a;
  end
  assign dut_o2 = d2b;

  // 0 good, 1 o[0] stuck-0, 2 OR, 3 NOR behind 2 flops, 4 o[3] stuck-1
  always_comb begin
    dut_o0 = ~(dut_x0 | dut_y0);
    case (mode)
      3'd1: dut_o0 = ~(dut_x0 | dut_y0) & 4'b1110;
      3'd2: dut_o0 = dut_x0 | dut_y0;
      3'd3: dut_o0 = m3b;
      3'd4: dut_o0 = ~(dut_x0 | dut_y0) | 4'b1000;
      default: dut_o0 = ~(dut_x0 | dut_y0);
    endcase
  end

  nor_4b_bist #(.DUT_LAT(0), .CNT_W(9)) u_b0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_x(dut_x0), .dut_y(dut_y0),
    .dut_o(dut_o0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_x(ffx0), .first_fail_y(ffy0)
  );

  nor_4b_bist #(.DUT_LAT(2), .CNT_W(9)) u_b2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_x(dut_x2), .dut_y(dut_y2),
    .dut_o(dut_o2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_x(ffx2), .first_fail_y(ffy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; pulses start for the chosen instance, optionally pulses it
  // again when the applied vector equals poke, and follows the sweep to done.
  task automatic sweep(input bit which, input int poke, output int s, output int bfirst,
                       output int bcnt, output int dfirst, output int e0);
    logic [7:0] v;
    logic       hit;
    s = cyc; bfirst = -1; bcnt = 0; dfirst = -1; e0 = -1;
    if (which) start2 = 1'b1; else start0 = 1'b1;
    for (int i = 0; i < 400 && dfirst < 0; i++) begin
      @(negedge clk);
      v   = which ? {dut_x2, dut_y2} : {dut_x0, dut_y0};
      hit = (poke >= 0) && (v == poke[7:0]);
      if (which) start2 = hit; else start0 = hit;
      if (i == 0) e0 = which ? int'(err2) : int'(err0);
      if (which ? busy2 : busy0) begin
        if (bfirst < 0) bfirst = cyc;
        bcnt++;
      end
      if (which ? done2 : done0) dfirst = cyc;
    end
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    int s, bf, bc, df, e0, k;
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; mode = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_ff", {ffx0, ffy0}, 0);
    chk("rst_vec", {dut_x0, dut_y0}, 0);
    chk("rst_busy2", busy2, 0);

    // Good NOR, start in cycle 10
    while (cyc < 10) @(negedge clk);
    sweep(0, -1, s, bf, bc, df, e0);
    chk("good_busy_first", bf, 11);
    chk("good_busy_cycles", bc, 256);
    chk("good_done_cycle", df, 267);
    chk("good_pass", pass0, 1);
    chk("good_err", err0, 0);
    chk("good_ff", {ffx0, ffy0}, 0);
    chk("good_hold_vec", {dut_x0, dut_y0}, 8'hFF);
    @(negedge clk);
    chk("good_done_held", done0, 1);

    // o[0] stuck-at-0
    mode = 3'd1;
    sweep(0, -1, s, bf, bc, df, e0);
    chk("sa0_err", err0, 64);
    chk("sa0_pass", pass0, 0);
    chk("sa0_ff", {ffx0, ffy0}, 8'h00);

    // Start from DONE clears results and reruns
    mode = 3'd0;
    sweep(0, -1, s, bf, bc, df, e0);
    chk("redo_err_cleared", e0, 0);
    chk("redo_done_time", df - s, 257);
    chk("redo_pass", pass0, 1);

    // OR instead of NOR
    mode = 3'd2;
    sweep(0, -1, s, bf, bc, df, e0);
    chk("or_err", err0, 256);
    chk("or_pass", pass0, 0);
    chk("or_ff", {ffx0, ffy0}, 8'h00);

    // o[3] stuck-at-1: first failure at x=0, y=8
    mode = 3'd4;
    sweep(0, -1, s, bf, bc, df, e0);
    chk("sa1_err", err0, 192);
    chk("sa1_ffx", ffx0, 0);
    chk("sa1_ffy", ffy0, 8);

    // Registered NOR with matching latency
    sweep(1, -1, s, bf, bc, df, e0);
    chk("lat2_done_time", df - s, 259);
    chk("lat2_busy_cycles", bc, 258);
    chk("lat2_pass", pass2, 1);
    chk("lat2_err", err2, 0);

    // Same registered NOR without latency compensation
    mode = 3'd3;
    sweep(0, -1, s, bf, bc, df, e0);
    chk("lat_mismatch_pass", pass0, 0);

    // start pulsed during RUN at vec=50 is ignored
    mode = 3'd0;
    sweep(0, 50, s, bf, bc, df, e0);
    chk("poke_done_time", df - s, 257);
    chk("poke_pass", pass0, 1);
    @(negedge clk);
    chk("poke_no_restart", busy0, 0);

    // Reset while vec=100
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while ({dut_x0, dut_y0} != 8'd100 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("reach_vec100", k < 300, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_vec", {dut_x0, dut_y0}, 0);
    chk("mid_rst_err", err0, 0);
    @(negedge clk);
    chk("mid_rst_idle", {busy0, done0, dut_x0, dut_y0}, 0);
    sweep(0, -1, s, bf, bc, df, e0);
    chk("after_rst_done_time", df - s, 257);
    chk("after_rst_pass", pass0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
